// File: rtl/pcs_verif_pkg.sv
// rtl/pcs_verif_pkg.sv - shared state encoding and read latency for the capture block
package pcs_verif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

  // Request-to-data latency: synchronous RAM read plus output register.
  localparam int READ_LATENCY = 2;

endpackage

// File: rtl/bram_capture_ctrl_if.sv
// rtl/bram_capture_ctrl_if.sv - sample stream and readout port bundle for bram_capture_ctrl
interface bram_capture_ctrl_if #(
  parameter int RAM_ADDR_NBIT = 5,
  parameter int DATA_WIDTH    = 22
);

  logic [DATA_WIDTH-1:0]    i_data;
  logic                     i_valid;
  logic                     i_enable_read;
  logic [RAM_ADDR_NBIT-1:0] i_read_address;
  logic [DATA_WIDTH-1:0]    o_read_data;
  logic                     o_read_valid;

  modport master (
    output i_data, i_valid, i_enable_read, i_read_address,
    input  o_read_data, o_read_valid
  );

  modport slave (
    input  i_data, i_valid, i_enable_read, i_read_address,
    output o_read_data, o_read_valid
  );

endinterface

// File: rtl/bram_sdp.sv
// rtl/bram_sdp.sv - simple dual-port RAM, one write port and one registered read port
module bram_sdp #(
  parameter int ADDR_NBIT  = 5,
  parameter int DATA_WIDTH = 22
) (
  input  logic                  i_clock,
  input  logic                  i_wr_en,
  input  logic [ADDR_NBIT-1:0]  i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_NBIT-1:0]  i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_NBIT)-1];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/bram_capture_ctrl.sv
// rtl/bram_capture_ctrl.sv - arm-triggered sample capture into BRAM with readout
// Optional decimation input enabled by defining BRAM_CAPTURE_DECIM_EN.
module bram_capture_ctrl
  import pcs_verif_pkg::*;
#(
  parameter int RAM_ADDR_NBIT = 5,
  parameter int DATA_WIDTH    = 22
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable_bram,
`ifdef BRAM_CAPTURE_DECIM_EN
  input  logic [3:0]             i_decim,
`endif
  output logic                   o_busy,
  output logic                   o_done,
  output logic [RAM_ADDR_NBIT:0] o_count,
  bram_capture_ctrl_if.slave     bus
);

  localparam logic [RAM_ADDR_NBIT:0] LAST_COUNT = (RAM_ADDR_NBIT+1)'((1 << RAM_ADDR_NBIT) - 1);

  cap_state_t              state;
  logic                    enable_q;
  logic                    arm_block;
  logic [RAM_ADDR_NBIT:0]  count;
  logic                    arm;
  logic                    take;
  logic                    wr_fire;
  logic                    rd_accept;
  logic                    rd_pipe;
  logic [DATA_WIDTH-1:0]   ram_q;

`ifdef BRAM_CAPTURE_DECIM_EN
  logic [3:0] decim_cnt;
  assign take = (decim_cnt == 4'd0);
`else
  assign take = 1'b1;
`endif

  // arm_block keeps a level held through reset from looking like a fresh arm.
  assign arm       = i_enable_bram && !enable_q && !arm_block;
  assign wr_fire   = (state == ST_CAPTURE) && bus.i_valid && take;
  assign rd_accept = bus.i_enable_read && (state != ST_CAPTURE);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      enable_q  <= 1'b0;
      arm_block <= 1'b1;
      count     <= '0;
`ifdef BRAM_CAPTURE_DECIM_EN
      decim_cnt <= 4'd0;
`endif
    end else begin
      enable_q <= i_enable_bram;
      if (!i_enable_bram) arm_block <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (arm) begin
            state <= ST_CAPTURE;
            count <= '0;
`ifdef BRAM_CAPTURE_DECIM_EN
            decim_cnt <= 4'd0;
`endif
          end
        end
        ST_CAPTURE: begin
          if (wr_fire) count <= count + 1'b1;
`ifdef BRAM_CAPTURE_DECIM_EN
          if (bus.i_valid) decim_cnt <= (decim_cnt == i_decim) ? 4'd0 : decim_cnt + 4'd1;
`endif
          // Deassertion wins over fill; the coinciding write still lands.
          if (!i_enable_bram)                        state <= ST_IDLE;
          else if (wr_fire && count == LAST_COUNT)   state <= ST_DONE;
        end
        ST_DONE: begin
          if (!i_enable_bram) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_pipe          <= 1'b0;
      bus.o_read_valid <= 1'b0;
      bus.o_read_data  <= '0;
    end else begin
      rd_pipe          <= rd_accept;
      bus.o_read_valid <= rd_pipe;
      if (rd_pipe) bus.o_read_data <= ram_q;
    end
  end

  bram_sdp #(
    .ADDR_NBIT  (RAM_ADDR_NBIT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clock   (i_clock),
    .i_wr_en   (wr_fire),
    .i_wr_addr (count[RAM_ADDR_NBIT-1:0]),
    .i_wr_data (bus.i_data),
    .i_rd_en   (rd_accept),
    .i_rd_addr (bus.i_read_address),
    .o_rd_data (ram_q)
  );

  assign o_busy  = (state == ST_CAPTURE);
  assign o_done  = (state == ST_DONE);
  assign o_count = count;

endmodule

// File: doc/bram_capture_ctrl.md
BRAM_CAPTURE_CTRL -- requirements
Module: bram_capture_ctrl

Interface
REQ-001 Parameter RAM_ADDR_NBIT, default 5: capture memory address width; depth is 2^RAM_ADDR_NBIT words.
REQ-002 Parameter DATA_WIDTH, default 22: captured sample width and read data width.
REQ-003 i_clock  input  1  sole clock; all logic on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_enable_bram  input  1  capture arm level from the register file.
REQ-006 i_enable_read  input  1  read request level, sampled every cycle.
REQ-007 i_read_address  input  RAM_ADDR_NBIT  word address for readout.
REQ-008 i_data  input  DATA_WIDTH  datapath sample.
REQ-009 i_valid  input  1  i_data qualifier.
REQ-010 o_read_data  output  DATA_WIDTH  registered read data.
REQ-011 o_read_valid  output  1  o_read_data is valid this cycle.
REQ-012 o_busy  output  1  high while in CAPTURE.
REQ-013 o_done  output  1  high while in DONE (memory full).
REQ-014 o_count  output  RAM_ADDR_NBIT+1  number of words written since last arm.

Function
REQ-015 The FSM SHALL have states IDLE, CAPTURE and DONE.
REQ-016 IDLE->CAPTURE on a rising edge of i_enable_bram (registered previous value 0, current 1); o_count and the write pointer SHALL clear on that edge.
REQ-017 In CAPTURE, each cycle with i_valid=1 SHALL write i_data at the write pointer, then increment the pointer and o_count.
REQ-018 The write that makes o_count equal 2^RAM_ADDR_NBIT SHALL move CAPTURE->DONE on the same edge; no further writes occur and the pointer does not wrap.
REQ-019 i_enable_bram=0 in CAPTURE or DONE SHALL return the FSM to IDLE next cycle; o_count holds its value; a write coinciding with deassertion completes.
REQ-020 Re-arming SHALL require a new rising edge; a level held high after DONE causes no recapture.
REQ-021 Reads SHALL be accepted only in IDLE or DONE: i_enable_read=1 in cycle N gives o_read_data = word[i_read_address] with o_read_valid=1 in cycle N+2 (synchronous RAM read plus output register).
REQ-022 Read requests in CAPTURE SHALL be ignored (o_read_valid=0); o_read_data holds its last value.
REQ-023 Addresses at or beyond o_count SHALL return stale RAM content; the block does not flag them.
REQ-024 o_busy and o_done SHALL be decoded from registered state, never both high.

Reset
REQ-025 Reset SHALL force IDLE, o_busy=0, o_done=0, o_count=0, o_read_valid=0, o_read_data=0, cleared pointers and edge-detect register; RAM contents are not cleared.
REQ-026 Reset in CAPTURE SHALL abort the capture; i_enable_bram held high through reset SHALL NOT arm until it falls and rises again.

Configuration
REQ-027 Macro BRAM_CAPTURE_DECIM_EN defined: the block SHALL add input i_decim (4 bits) and write only every (i_decim+1)-th valid sample, the decimation counter clearing on arm.
REQ-028 Macro undefined: no i_decim port; every valid sample in CAPTURE is written.

Structure
REQ-029 State encoding and the read latency constant (2) SHALL live in shared package pcs_verif_pkg.
REQ-030 The memory SHALL be a sub-module bram_sdp (simple dual-port, one write port, one registered-read port).

Verification
REQ-031 Reset, rising edge on i_enable_bram, 32 consecutive valids with data 0..31 -> o_busy for 32 cycles, o_done=1, o_count=32.
REQ-032 After REQ-031, read addresses 0, 5, 31 -> o_read_data 0, 5, 31 exactly 2 cycles after each request.
REQ-033 Arm, 10 valids, drop i_enable_bram -> IDLE, o_count=10, o_done=0; reading address 9 returns 9.
REQ-034 Read request during CAPTURE -> o_read_valid stays 0.
REQ-035 i_reset asserted after 7 writes, i_enable_bram held high -> IDLE, o_count=0, no capture until a new rising edge.
REQ-036 With BRAM_CAPTURE_DECIM_EN and i_decim=3, 128 valids of data 0..127 -> RAM holds 0,4,8,...,124 and o_done=1.
